// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - USB 1.1 receive bit timer and word framer
//
// Recovers the bit clock from an oversampled NRZI line. The phase counter
// re-phases on every d_edge; shift_en is a registered one-cycle strobe issued
// at SAMPLE_PHASE of each bit period. Non-stuffed strobes are counted into
// words and word_rcvd pulses for one cycle when a word completes.
//
// Optional feature: define RX_BIT_TIMER_SYNC_CHK_EN to build the edge-loss
// detector (run counter + sticky sync_err). Without it sync_err is tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   d_edge     in   one-cycle pulse on a line transition
//   rcving     in   high for the duration of a packet
//   bit_stuff  in   current sample is a stuffed bit
//   shift_en   out  one-cycle sample strobe
//   word_rcvd  out  one-cycle pulse, cycle after the strobe taking the last bit
//   bit_cnt    out  non-stuffed bits accepted in the current word
//   sync_err   out  sticky loss-of-transition flag

module rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_PHASE  = 3,
    parameter int BITS_PER_WORD = 8,
    parameter int MAX_RUN       = 7
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               d_edge,
    input  logic                               rcving,
    input  logic                               bit_stuff,
    output logic                               shift_en,
    output logic                               word_rcvd,
    output logic [$clog2(BITS_PER_WORD+1)-1:0] bit_cnt,
    output logic                               sync_err
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(BITS_PER_WORD + 1);

    localparam logic [PW-1:0] LAST_PH   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] SAMPLE_PH = PW'(SAMPLE_PHASE);
    localparam logic [CW-1:0] LAST_BIT  = CW'(BITS_PER_WORD - 1);

    if (CLKS_PER_BIT < 2 || SAMPLE_PHASE < 0 || SAMPLE_PHASE >= CLKS_PER_BIT ||
        BITS_PER_WORD < 2 || MAX_RUN < 1) begin : g_param_check
        $error("rx_bit_timer: illegal parameter set");
    end

    logic [PW-1:0] phase;
    logic [PW-1:0] eph;

    // An edge forces phase 0 in its own cycle, so an edge landing on the
    // would-be sample point suppresses that strobe.
    always_comb begin
        eph = phase;
        if (d_edge) begin
            eph = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase     <= '0;
            shift_en  <= 1'b0;
            word_rcvd <= 1'b0;
            bit_cnt   <= '0;
        end else if (!rcving) begin
            // Idle also discards any partial word.
            phase     <= '0;
            shift_en  <= 1'b0;
            word_rcvd <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            phase     <= (eph == LAST_PH) ? '0 : eph + 1'b1;
            shift_en  <= (eph == SAMPLE_PH);
            word_rcvd <= 1'b0;
            // Stuffed bits are strobed but not counted.
            if (shift_en && !bit_stuff) begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    word_rcvd <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RX_BIT_TIMER_SYNC_CHK_EN
    localparam int RW = $clog2(MAX_RUN + 2);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_RUN + 1);

    logic [RW-1:0] run_cnt;

    // Counts strobes since the last edge; saturates one past the allowed run.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run_cnt  <= '0;
            sync_err <= 1'b0;
        end else if (!rcving) begin
            run_cnt  <= '0;
            sync_err <= 1'b0;
        end else begin
            if (d_edge) begin
                run_cnt <= '0;
            end else if (shift_en && run_cnt != RUN_LIMIT) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (run_cnt == RUN_LIMIT) begin
                sync_err <= 1'b1;
            end
        end
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb/tb_rx_bit_timer.sv - scoreboard bench for rx_bit_timer (default parameters)

module tb_rx_bit_timer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       rcving;
    logic       bit_stuff;
    logic       shift_en;
    logic       word_rcvd;
    logic [3:0] bit_cnt;
    logic       sync_err;

    always #5 clk = ~clk;

    rx_bit_timer dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .d_edge    (d_edge),
        .rcving    (rcving),
        .bit_stuff (bit_stuff),
        .shift_en  (shift_en),
        .word_rcvd (word_rcvd),
        .bit_cnt   (bit_cnt),
        .sync_err  (sync_err)
    );

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sq[$];
    exp_t wq[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base  = 0;
    bit playing = 1'b0;

    bit rcv_p   [128];
    bit edge_p  [128];
    bit stuff_p [128];
    int sync_p  [128];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT strobes.
    always @(negedge clk) begin
        exp_t e;
        int   rel;
        rel = cyc - base;
        if (shift_en) begin
            if (sq.size() == 0) begin
                chk("strobe_unexpected", rel, -1);
            end else begin
                e = sq.pop_front();
                chk("strobe_cycle", rel, e.cyc);
                chk("strobe_bit_cnt", int'(bit_cnt), e.cnt);
            end
        end
        if (word_rcvd) begin
            if (wq.size() == 0) begin
                chk("word_unexpected", rel, -1);
            end else begin
                e = wq.pop_front();
                chk("word_cycle", rel, e.cyc);
                chk("word_bit_cnt", int'(bit_cnt), e.cnt);
            end
        end
        if (playing && rel >= 0 && rel < 128 && sync_p[rel] != 2) begin
            chk("sync_err", int'(sync_err), sync_p[rel]);
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 128; i++) begin
            rcv_p[i]   = 1'b0;
            edge_p[i]  = 1'b0;
            stuff_p[i] = 1'b0;
            sync_p[i]  = 2;
        end
    endtask

    task automatic plan_rcv(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) rcv_p[i] = 1'b1;
    endtask

    task automatic plan_edges(input int lo, input int hi, input int stp);
        for (int i = lo; i <= hi; i += stp) edge_p[i] = 1'b1;
    endtask

    task automatic exp_strobe(input int c, input int k);
        sq.push_back('{c, k});
    endtask

    task automatic exp_word(input int c);
        wq.push_back('{c, 0});
    endtask

    task automatic play(input int n);
        base    = cyc + 1;
        playing = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rcving    = rcv_p[i];
            d_edge    = edge_p[i];
            bit_stuff = stuff_p[i];
        end
        @(posedge clk);
        #1;
        rcving    = 1'b0;
        d_edge    = 1'b0;
        bit_stuff = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        playing = 1'b0;
        chk("strobes_left", sq.size(), 0);
        chk("words_left", wq.size(), 0);
    endtask

    // Eight clean bits, edges on every bit boundary: strobes at 4+8k.
    task automatic word_test();
        clear_plan();
        plan_rcv(0, 62);
        plan_edges(0, 56, 8);
        for (int k = 0; k < 8; k++) exp_strobe(4 + 8 * k, k);
        exp_word(61);
        sync_p[62] = 0;
        play(64);
    endtask

    initial begin
        n_rst     = 1'b0;
        rcving    = 1'b1;
        d_edge    = 1'b0;
        bit_stuff = 1'b0;

        // Reset holds everything low despite activity.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            d_edge = ~d_edge;
        end
        @(negedge clk);
        chk("rst_shift_en", int'(shift_en), 0);
        chk("rst_word_rcvd", int'(word_rcvd), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        @(posedge clk);
        #1;
        rcving = 1'b0;
        d_edge = 1'b0;
        n_rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single edge at 10 after a quiet start at 7.
        clear_plan();
        plan_rcv(7, 31);
        edge_p[10] = 1'b1;
        exp_strobe(14, 0);
        exp_strobe(22, 1);
        exp_strobe(30, 2);
        play(33);

        word_test();

        // Stuffed 4th strobe: count holds, word after the 9th strobe.
        clear_plan();
        plan_rcv(0, 70);
        plan_edges(0, 64, 8);
        stuff_p[28] = 1'b1;
        exp_strobe(4, 0);
        exp_strobe(12, 1);
        exp_strobe(20, 2);
        exp_strobe(28, 3);
        exp_strobe(36, 3);
        exp_strobe(44, 4);
        exp_strobe(52, 5);
        exp_strobe(60, 6);
        exp_strobe(68, 7);
        exp_word(69);
        play(72);

        // Re-phase by an early edge at 6.
        clear_plan();
        plan_rcv(0, 20);
        edge_p[0] = 1'b1;
        edge_p[6] = 1'b1;
        exp_strobe(4, 0);
        exp_strobe(10, 1);
        exp_strobe(18, 2);
        play(22);

        // Edge on the sample phase suppresses that strobe.
        clear_plan();
        plan_rcv(0, 17);
        edge_p[0] = 1'b1;
        edge_p[3] = 1'b1;
        exp_strobe(7, 0);
        exp_strobe(15, 1);
        play(19);

        // Abort after 5 bits, then a fresh full word.
        clear_plan();
        plan_rcv(0, 37);
        plan_edges(0, 32, 8);
        for (int k = 0; k < 5; k++) exp_strobe(4 + 8 * k, k);
        play(40);
        chk("abort_bit_cnt", int'(bit_cnt), 0);
        word_test();

`ifdef RX_BIT_TIMER_SYNC_CHK_EN
        // No edges after 0: sync_err rises two cycles after the 8th strobe.
        clear_plan();
        plan_rcv(0, 77);
        edge_p[0] = 1'b1;
        for (int k = 0; k < 8; k++) exp_strobe(4 + 8 * k, k);
        exp_strobe(68, 0);
        exp_strobe(76, 1);
        exp_word(61);
        sync_p[60] = 0;
        sync_p[61] = 0;
        sync_p[62] = 1;
        sync_p[77] = 1;
        sync_p[79] = 0;
        play(80);

        // Edge at 48 restarts the run; flag stays low.
        clear_plan();
        plan_rcv(0, 77);
        edge_p[0]  = 1'b1;
        edge_p[48] = 1'b1;
        for (int k = 0; k < 8; k++) exp_strobe(4 + 8 * k, k);
        exp_strobe(68, 0);
        exp_strobe(76, 1);
        exp_word(61);
        sync_p[62] = 0;
        sync_p[77] = 0;
        play(80);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
